// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: a write lands at edge E, tx_start rises after E+1 when idle.
// A write into a full FIFO is dropped with a one-cycle overflow pulse unless a pop frees a slot that cycle.
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                pop;
    logic                push;
    logic [ADDR_W:0]     count_nxt;

    // A pop is legal from IDLE or DRAIN; empty is registered, so a fresh write never falls through.
    always_comb begin
        pop       = (state != SEND) && !empty && !tx_busy;
        push      = wr_en && (!full || pop);
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            state    <= IDLE;
        end else begin
            overflow <= wr_en && full && !pop;
            count    <= count_nxt;
            full     <= (count_nxt == FULL_CNT);
            empty    <= (count_nxt == '0);
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                tx_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                tx_start <= 1'b1;
                state    <= SEND;
            end else begin
                case (state)
                    SEND: begin
                        if (tx_busy) begin
                            tx_start <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!tx_busy) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        state <= IDLE;
                    end
                    default: begin
                        tx_start <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo with a queue-based reference and a simple UART responder.
module tb_uart_tx_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;

    uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: bytes waiting in the FIFO, plus the one handed out and not yet acknowledged.
    logic [7:0] q[$];
    bit         m_pending = 1'b0;
    logic [7:0] m_tx_data = 8'h00;
    bit         m_ovf = 1'b0;

    logic [7:0] exp_rx[$];
    logic [7:0] rx[$];
    logic [7:0] sent[$];

    // UART responder knobs and state.
    bit busy_force = 1'b0;
    int ack_delay  = 1;
    int busy_len   = 1;
    int wait_cnt   = 0;
    int busy_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit pop_m;
        bit push_m;
        if (rst) begin
            q.delete();
            m_pending = 1'b0;
            m_tx_data = 8'h00;
            m_ovf     = 1'b0;
        end else begin
            pop_m  = (q.size() != 0) && !m_pending && !tx_busy;
            push_m = wr_en && ((q.size() < DEPTH) || pop_m);
            m_ovf  = wr_en && (q.size() == DEPTH) && !pop_m;
            if (pop_m) begin
                m_tx_data = q.pop_front();
                m_pending = 1'b1;
            end else if (m_pending && tx_busy) begin
                m_pending = 1'b0;
                exp_rx.push_back(m_tx_data);
            end
            if (push_m) q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
        check("count",    count,    q.size());
        check("empty",    empty,    q.size() == 0);
        check("full",     full,     q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("tx_start", tx_start, m_pending);
        check("tx_data",  tx_data,  m_tx_data);
        if (busy_force) begin
            tx_busy = 1'b1;
        end else if (tx_busy) begin
            if (busy_cnt > 0) busy_cnt--;
            else tx_busy = 1'b0;
        end else if (tx_start) begin
            if (wait_cnt + 1 >= ack_delay) begin
                rx.push_back(tx_data);
                tx_busy  = 1'b1;
                busy_cnt = busy_len - 1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (!((q.size() == 0) && !m_pending && !tx_busy) && n < 2000) begin
            step();
            n++;
        end
        check("drain_done", n < 2000, 1);
    endtask

    initial begin
        int base;
        int guard;
        logic [7:0] last;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        step();
        step();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        step();

        // Single byte with a one-cycle acknowledge.
        ack_delay = 1;
        busy_len  = 3;
        base      = rx.size();
        wr_data   = 8'hA5;
        wr_en     = 1'b1;
        step();
        wr_en = 1'b0;
        check("single_no_fallthrough", tx_start, 0);
        step();
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'hA5);
        step();
        check("single_ack_drop", tx_start, 0);
        drain();
        check("single_count", count, 0);
        check("single_rx_n", rx.size() - base, 1);
        check("single_rx", rx[rx.size()-1], 8'hA5);

        // Burst into a stalled UART, then overflow.
        busy_force = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i + 1);
            wr_en   = 1'b1;
            step();
        end
        check("burst_full", full, 1);
        check("burst_count", count, 16);
        wr_data = 8'hFF;
        step();
        check("burst_ovf", overflow, 1);
        check("burst_ovf_count", count, 16);
        wr_en = 1'b0;
        step();
        check("burst_ovf_once", overflow, 0);
        base       = rx.size();
        busy_force = 1'b0;
        busy_len   = 2;
        drain();
        check("burst_rx_n", rx.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < rx.size()) check("burst_rx", rx[base+i], 8'(i + 1));
        end

        // Write and pop in the same cycle while full.
        busy_force = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'($urandom);
            wr_en   = 1'b1;
            step();
        end
        wr_en      = 1'b0;
        base       = rx.size();
        busy_force = 1'b0;
        step();
        wr_data = 8'hEE;
        wr_en   = 1'b1;
        step();
        wr_en = 1'b0;
        check("simul_count", count, 16);
        check("simul_ovf", overflow, 0);
        check("simul_start", tx_start, 1);
        drain();
        check("simul_rx_n", rx.size() - base, 17);
        check("simul_last", rx[rx.size()-1], 8'hEE);

        // Stream 40 random bytes through a slow UART to wrap both pointers.
        busy_len = 10;
        base     = rx.size();
        sent.delete();
        guard    = 0;
        while (sent.size() < 40 && guard < 5000) begin
            if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                last    = 8'($urandom);
                wr_data = last;
                wr_en   = 1'b1;
                sent.push_back(last);
            end else begin
                wr_en = 1'b0;
            end
            step();
            guard++;
        end
        wr_en = 1'b0;
        drain();
        check("wrap_rx_n", rx.size() - base, 40);
        for (int i = 0; i < 40; i++) begin
            if (base + i < rx.size() && i < sent.size()) check("wrap_rx", rx[base+i], sent[i]);
        end
        check("wrap_empty", empty, 1);

        // Reset while a request is outstanding.
        ack_delay = 10;
        busy_len  = 2;
        base      = rx.size();
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'($urandom);
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        check("rst_mid_start", tx_start, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_tx_data", tx_data, 8'h00);
        busy_force = 1'b1;
        step();
        wr_data = 8'h3C;
        wr_en   = 1'b1;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_busy_no_pop", tx_start, 0);
        end
        busy_force = 1'b0;
        ack_delay  = 1;
        drain();
        check("rst_rx_n", rx.size() - base, 1);
        check("rst_rx", rx[rx.size()-1], 8'h3C);

        // Slow acknowledge: request held stable, one pop only.
        ack_delay = 4;
        busy_len  = 2;
        base      = rx.size();
        wr_data   = 8'h5A;
        wr_en     = 1'b1;
        step();
        wr_data = 8'h6B;
        step();
        wr_en = 1'b0;
        check("slow_start", tx_start, 1);
        check("slow_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("slow_hold_start", tx_start, 1);
            check("slow_hold_data", tx_data, 8'h5A);
            check("slow_one_pop", count, 1);
        end
        step();
        check("slow_ack_drop", tx_start, 0);
        drain();
        check("slow_rx_n", rx.size() - base, 2);
        if (rx.size() >= 2) begin
            check("slow_rx0", rx[rx.size()-2], 8'h5A);
            check("slow_rx1", rx[rx.size()-1], 8'h6B);
        end

        // Everything the UART captured must match what the reference says it accepted.
        check("total_rx_n", rx.size(), exp_rx.size());
        for (int i = 0; i < rx.size(); i++) begin
            if (i < exp_rx.size()) check("order", rx[i], exp_rx[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
